muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, operand/HI/LO width (legal range 4..64).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset; one clock; reset is synchronous and active-high.
REQ-004 SHALL have port start  input  1  request a new operation; sampled only in IDLE.
REQ-005 SHALL have port op  input  2  operation: 2'b00 MULT, 2'b01 MULTU, 2'b10 DIV, 2'b11 DIVU.
REQ-006 SHALL have port operand_1  input  DATA_WIDTH  multiplicand / dividend.
REQ-007 SHALL have port operand_2  input  DATA_WIDTH  multiplier / divisor.
REQ-008 SHALL have port flush  input  1  abort any operation in progress.
REQ-009 SHALL have port busy  output  1  high while an operation is iterating (pipeline stall request).
REQ-010 SHALL have port done  output  1  one-cycle pulse: hi/lo just updated.
REQ-011 SHALL have port hi  output  DATA_WIDTH  registered HI: product upper half / remainder.
REQ-012 SHALL have port lo  output  DATA_WIDTH  registered LO: product lower half / quotient.

Function
REQ-013 SHALL implement states IDLE, CALC, DONE; busy = (state==CALC), done = (state==DONE), both registered-state decodes.
REQ-014 SHALL, in IDLE with start=1 and flush=0, latch op and operands, clear iteration counter, enter CALC next cycle.
REQ-015 SHALL perform exactly one radix-2 step per CALC cycle (shift-add multiply, restoring divide) on operand magnitudes.
REQ-016 SHALL leave CALC for DONE after exactly DATA_WIDTH steps; done high in cycle E+DATA_WIDTH+1, E = edge sampling start.
REQ-017 SHALL write hi/lo on the edge entering DONE; hi/lo hold value at all other times.
REQ-018 SHALL go DONE -> IDLE unconditionally after one cycle; start in DONE ignored; back-to-back start accepted in the IDLE cycle after.
REQ-019 SHALL ignore start while in CALC or DONE (no re-latch of operands).
REQ-020 SHALL for MULTU/DIVU treat operands unsigned; for MULT/DIV use absolute values (two's-complement negate when MSB set).
REQ-021 SHALL for MULT negate the full 2*DATA_WIDTH product when operand signs differ; {hi,lo} = product.
REQ-022 SHALL for DIV negate quotient when signs differ and give remainder the dividend's sign; lo = quotient, hi = remainder.
REQ-023 SHALL for DIV of most-negative by -1 give lo = most-negative, hi = 0 (no trap).
REQ-024 SHALL for divisor = 0 (DIV or DIVU) give hi = operand_1, lo = all ones, same latency, done pulsed.
REQ-025 SHALL on flush=1 in any state go IDLE next cycle, no hi/lo write, no done; flush overrides simultaneous start.
REQ-026 SHALL, if flush coincides with the final CALC step, suppress the DONE transition and hi/lo write.
REQ-027 SHALL use an iteration counter of width $clog2(DATA_WIDTH+1); no wrap past DATA_WIDTH.

Reset
REQ-028 SHALL on rst=1 at a clock edge set state IDLE, busy=0, done=0, hi=0, lo=0, counter=0, regardless of state.
REQ-029 SHALL give rst priority over flush and start; operation in progress discarded with no done pulse.

Verification
REQ-030 SHALL pass: MULTU 0xFFFFFFFF*0xFFFFFFFF, start at edge E -> busy cycles E+1..E+32, done at E+33, hi=0xFFFFFFFE, lo=0x00000001.
REQ-031 SHALL pass: MULT 0xFFFFFFFD(-3)*0x00000005 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
REQ-032 SHALL pass: DIV 0xFFFFFFF9(-7)/0x00000002 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-033 SHALL pass: DIVU 0x0000000A/0 -> hi=0x0000000A, lo=0xFFFFFFFF, done at E+33.
REQ-034 SHALL pass: MULT started, flush at 10th CALC cycle -> busy=0 next cycle, no done, hi/lo keep previous result; rst mid-op -> hi=lo=0.
REQ-035 SHALL pass: start held high continuously for two ops -> second accepted in IDLE after done, both results correct, DATA_WIDTH=8 and 32 builds.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit: one radix-2 step per clock.
// Shift-add multiply, restoring divide, sign fix-up on the last step.
module muldiv_unit #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [1:0]            op,
   input  logic [DATA_WIDTH-1:0] operand_1,
   input  logic [DATA_WIDTH-1:0] operand_2,
   input  logic                  flush,
   output logic                  busy,
   output logic                  done,
   output logic [DATA_WIDTH-1:0] hi,
   output logic [DATA_WIDTH-1:0] lo
);

   localparam int W  = DATA_WIDTH;
   localparam int CW = $clog2(W + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t          state;
   logic [CW-1:0]   cnt;
   logic            is_div;
   logic            neg_res;
   logic            neg_rem;
   logic            div_zero;
   logic [W-1:0]    op1_raw;
   logic [W-1:0]    acc;
   logic [W-1:0]    sh;
   logic [W-1:0]    mag2;

   logic            sgn_op;
   logic            s1;
   logic            s2;
   logic [W-1:0]    mag1_in;
   logic [W-1:0]    mag2_in;

   logic [W:0]      sum;
   logic [W:0]      shifted;
   logic            ge;
   logic [W-1:0]    diff;
   logic [W-1:0]    acc_nxt;
   logic [W-1:0]    sh_nxt;
   logic [2*W-1:0]  prod;
   logic [W-1:0]    res_hi;
   logic [W-1:0]    res_lo;

   assign busy = (state == CALC);
   assign done = (state == DONE);

   // Operand magnitudes; op[0]=0 selects the signed variants.
   always_comb begin
      sgn_op  = ~op[0];
      s1      = sgn_op & operand_1[W-1];
      s2      = sgn_op & operand_2[W-1];
      mag1_in = s1 ? -operand_1 : operand_1;
      mag2_in = s2 ? -operand_2 : operand_2;
   end

   always_comb begin
      sum     = {1'b0, acc} + (sh[0] ? {1'b0, mag2} : '0);
      shifted = {acc, sh[W-1]};
      ge      = (shifted >= {1'b0, mag2});
      diff    = shifted[W-1:0] - mag2;
      if (is_div) begin
         acc_nxt = ge ? diff : shifted[W-1:0];
         sh_nxt  = {sh[W-2:0], ge};
      end else begin
         acc_nxt = sum[W:1];
         sh_nxt  = {sum[0], sh[W-1:1]};
      end
      prod = {acc_nxt, sh_nxt};
      if (neg_res) prod = -prod;
      res_hi = prod[2*W-1:W];
      res_lo = prod[W-1:0];
      if (is_div) begin
         // Divide by zero bypasses the datapath result entirely.
         if (div_zero) begin
            res_hi = op1_raw;
            res_lo = '1;
         end else begin
            res_hi = neg_rem ? -acc_nxt : acc_nxt;
            res_lo = neg_res ? -sh_nxt : sh_nxt;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= '0;
         is_div   <= 1'b0;
         neg_res  <= 1'b0;
         neg_rem  <= 1'b0;
         div_zero <= 1'b0;
         op1_raw  <= '0;
         acc      <= '0;
         sh       <= '0;
         mag2     <= '0;
         hi       <= '0;
         lo       <= '0;
      end else if (flush) begin
         state <= IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state    <= CALC;
                  cnt      <= '0;
                  is_div   <= op[1];
                  neg_res  <= s1 ^ s2;
                  neg_rem  <= s1;
                  div_zero <= (operand_2 == '0);
                  op1_raw  <= operand_1;
                  acc      <= '0;
                  sh       <= mag1_in;
                  mag2     <= mag2_in;
               end
            end
            CALC: begin
               acc <= acc_nxt;
               sh  <= sh_nxt;
               cnt <= cnt + CW'(1);
               if (cnt == CW'(W - 1)) begin
                  state <= DONE;
                  hi    <= res_hi;
                  lo    <= res_lo;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: vector table plus flush/reset/back-to-back
// sequences on a 32-bit instance and a back-to-back sequence on an 8-bit one.
module tb_muldiv_unit;

   localparam int W = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [1:0]    op;
   logic [W-1:0]  a;
   logic [W-1:0]  b;
   logic          flush;
   logic          busy;
   logic          done;
   logic [W-1:0]  hi;
   logic [W-1:0]  lo;

   logic          start8;
   logic [1:0]    op8;
   logic [7:0]    a8;
   logic [7:0]    b8;
   logic          flush8;
   logic          busy8;
   logic          done8;
   logic [7:0]    hi8;
   logic [7:0]    lo8;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   muldiv_unit #(.DATA_WIDTH(W)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op),
      .operand_1(a), .operand_2(b), .flush(flush),
      .busy(busy), .done(done), .hi(hi), .lo(lo)
   );

   muldiv_unit #(.DATA_WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .start(start8), .op(op8),
      .operand_1(a8), .operand_2(b8), .flush(flush8),
      .busy(busy8), .done(done8), .hi(hi8), .lo(lo8)
   );

   typedef struct {
      logic [1:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] hi;
      logic [W-1:0] lo;
   } vec_t;

   vec_t vecs[12];

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Issue one op; lat = negedges after the accepting edge until done.
   task automatic run32(input logic [1:0] o, input logic [W-1:0] x,
                        input logic [W-1:0] y, input int flush_at,
                        input int rst_at, output int lat, output int nb);
      @(negedge clk);
      start = 1'b1; op = o; a = x; b = y;
      @(posedge clk);
      lat = 0; nb = 0;
      while (lat < 200) begin
         @(negedge clk);
         start = 1'b0;
         lat++;
         if (busy) nb++;
         if (done) break;
         if (lat == flush_at) flush = 1'b1;
         if (lat == rst_at) rst = 1'b1;
         if (lat == flush_at || lat == rst_at) break;
      end
   endtask

   task automatic no_done(input string name, input int cycles);
      int seen = 0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         if (done) seen++;
      end
      check(name, 64'(seen), 64'd0);
   endtask

   initial begin
      int lat;
      int nb;
      vecs[0]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
      vecs[1]  = '{2'b00, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1};
      vecs[2]  = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
      vecs[3]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
      vecs[4]  = '{2'b11, 32'h0000000A, 32'h00000000, 32'h0000000A, 32'hFFFFFFFF};
      vecs[5]  = '{2'b10, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF};
      vecs[6]  = '{2'b01, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780};
      vecs[7]  = '{2'b11, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E};
      vecs[8]  = '{2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
      vecs[9]  = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
      vecs[10] = '{2'b00, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000001};
      vecs[11] = '{2'b11, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF};

      rst = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0; flush = 1'b0;
      start8 = 1'b0; op8 = 2'b00; a8 = '0; b8 = '0; flush8 = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_hi", 64'(hi), 64'd0);
      check("rst_lo", 64'(lo), 64'd0);
      check("rst_hi8", 64'(hi8), 64'd0);
      rst = 1'b0;

      for (int i = 0; i < 12; i++) begin
         run32(vecs[i].op, vecs[i].a, vecs[i].b, -1, -1, lat, nb);
         check($sformatf("v%0d_latency", i), 64'(lat), 64'(W + 1));
         check($sformatf("v%0d_busy_cycles", i), 64'(nb), 64'(W));
         check($sformatf("v%0d_hi", i), 64'(hi), 64'(vecs[i].hi));
         check($sformatf("v%0d_lo", i), 64'(lo), 64'(vecs[i].lo));
      end

      // Flush in 10th CALC cycle: result regs keep vector 11's values.
      run32(2'b00, 32'h00000003, 32'h00000003, 10, -1, lat, nb);
      @(negedge clk);
      flush = 1'b0;
      check("flush10_busy", 64'(busy), 64'd0);
      check("flush10_done", 64'(done), 64'd0);
      check("flush10_hi", 64'(hi), 64'h00000000);
      check("flush10_lo", 64'(lo), 64'hFFFFFFFF);
      no_done("flush10_no_done", W + 4);

      // Flush coinciding with the final step.
      run32(2'b01, 32'h00000005, 32'h00000005, W, -1, lat, nb);
      @(negedge clk);
      flush = 1'b0;
      check("flushlast_done", 64'(done), 64'd0);
      check("flushlast_busy", 64'(busy), 64'd0);
      check("flushlast_hi", 64'(hi), 64'h00000000);
      check("flushlast_lo", 64'(lo), 64'hFFFFFFFF);
      no_done("flushlast_no_done", 4);

      // Flush beats start in IDLE.
      @(negedge clk);
      start = 1'b1; flush = 1'b1;
      @(negedge clk);
      check("flush_vs_start_busy", 64'(busy), 64'd0);
      start = 1'b0; flush = 1'b0;

      // Start held high: second op latched only after DONE.
      @(negedge clk);
      start = 1'b1; op = 2'b01; a = 32'h00000006; b = 32'h00000007;
      @(posedge clk);
      @(negedge clk);
      op = 2'b11; a = 32'h00000011; b = 32'h00000005;
      lat = 1;
      while (!done && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      check("b2b_first_latency", 64'(lat), 64'(W + 1));
      check("b2b_first_hi", 64'(hi), 64'h00000000);
      check("b2b_first_lo", 64'(lo), 64'h0000002A);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!done && lat < 200);
      start = 1'b0;
      check("b2b_second_latency", 64'(lat), 64'(W + 2));
      check("b2b_second_hi", 64'(hi), 64'h00000002);
      check("b2b_second_lo", 64'(lo), 64'h00000003);

      // 8-bit build, same held-start pattern.
      @(negedge clk);
      start8 = 1'b1; op8 = 2'b01; a8 = 8'hFF; b8 = 8'hFF;
      @(posedge clk);
      @(negedge clk);
      op8 = 2'b10; a8 = 8'hF9; b8 = 8'h02;
      lat = 1;
      while (!done8 && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      check("w8_first_latency", 64'(lat), 64'd9);
      check("w8_first_hi", 64'(hi8), 64'hFE);
      check("w8_first_lo", 64'(lo8), 64'h01);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!done8 && lat < 200);
      start8 = 1'b0;
      check("w8_second_latency", 64'(lat), 64'd10);
      check("w8_second_hi", 64'(hi8), 64'hFF);
      check("w8_second_lo", 64'(lo8), 64'hFD);

      // Reset mid-operation clears results and drops the op.
      run32(2'b00, 32'h00000009, 32'h00000009, -1, 5, lat, nb);
      @(negedge clk);
      rst = 1'b0;
      check("rstmid_busy", 64'(busy), 64'd0);
      check("rstmid_done", 64'(done), 64'd0);
      check("rstmid_hi", 64'(hi), 64'd0);
      check("rstmid_lo", 64'(lo), 64'd0);
      no_done("rstmid_no_done", W + 4);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
